// File: rtl/ntt_job_arbiter.sv
// ntt_job_arbiter
//   Round-robin arbiter that sequences jobs from two requesters onto a single
//   16-point SDF NTT/INTT core and tracks the core's output beats.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid[1:0]        per-requester job request
//   req_mode[1:0]         per-requester transform type (0 = NTT, 1 = INTT)
//   req_ready[1:0]        one-cycle accept pulse to the winner (IDLE only)
//   gnt[1:0]              one-hot owner of the core while a job is in flight
//   core_start            one-cycle start strobe, only while core_busy is low
//   core_ntt_en/intt_en   mode enables, held from START through CMPL
//   core_busy, core_done_tick, core_data_valid   core status inputs
//   out_beat[3:0]         index of the current valid output beat (wraps 15->0)
//   done[1:0]             one-cycle job-complete pulse to the owner
//   err                   one-cycle abort pulse (only with ARB_TIMEOUT_EN)
//
// Build option
//   ARB_TIMEOUT_EN        adds a 6-bit RUN watchdog that aborts after 60 cycles
//                         without core_done_tick and exposes the err port.
//
// req_ready, core_start and done are decoded from the current state (and
// core_busy / req_valid) so that the accept and the start strobe land in the
// same cycle as the condition that allows them; every other output is a
// register.
module ntt_job_arbiter #(
  localparam int unsigned NUM_REQ = 2,
  localparam int unsigned BEAT_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic               core_start,
  output logic               core_ntt_en,
  output logic               core_intt_en,
  input  logic               core_busy,
  input  logic               core_done_tick,
  input  logic               core_data_valid,
  output logic [BEAT_W-1:0]  out_beat,
  output logic [NUM_REQ-1:0] done
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    CMPL  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 rr_q, rr_d;          // index of the most recent grant
  logic                 ntt_en_q, ntt_en_d;
  logic                 intt_en_q, intt_en_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 win_idx;
  logic [NUM_REQ-1:0]   win_vec;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WD_W     = 6;
  localparam int unsigned WD_LIMIT = 60;

  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 err_q, err_d;
`endif

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    win_idx = 1'b0;
    if (req_valid == 2'b11) begin
      win_idx = ~rr_q;
    end else if (req_valid[1]) begin
      win_idx = 1'b1;
    end
    win_vec = (|req_valid) ? (NUM_REQ'(1) << win_idx) : '0;
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    ntt_en_d   = ntt_en_q;
    intt_en_d  = intt_en_q;
    beat_d     = beat_q;
    req_ready  = '0;
    core_start = 1'b0;
    done       = '0;
`ifdef ARB_TIMEOUT_EN
    wd_d       = wd_q;
    err_d      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = win_vec;
          gnt_d     = win_vec;
          ntt_en_d  = ~req_mode[win_idx];
          intt_en_d = req_mode[win_idx];
          beat_d    = '0;
          state_d   = START;
        end
      end

      START: begin
        if (!core_busy) begin
          core_start = 1'b1;
          state_d    = RUN;
`ifdef ARB_TIMEOUT_EN
          wd_d       = '0;
`endif
        end
      end

      RUN: begin
        if (core_data_valid) begin
          beat_d = beat_q + BEAT_W'(1);
        end
        if (core_done_tick) begin
          state_d = CMPL;
        end
`ifdef ARB_TIMEOUT_EN
        // Watchdog fires on the 60th consecutive RUN cycle without a done tick.
        else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
          state_d = CMPL;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end

      CMPL: begin
`ifdef ARB_TIMEOUT_EN
        done = err_q ? '0 : gnt_q;
`else
        done = gnt_q;
`endif
        gnt_d     = '0;
        rr_d      = gnt_q[1];
        ntt_en_d  = 1'b0;
        intt_en_d = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Decoded strobes are suppressed during the reset cycle itself.
    if (rst) begin
      req_ready  = '0;
      core_start = 1'b0;
      done       = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_q      <= 1'b1;
      ntt_en_q  <= 1'b0;
      intt_en_q <= 1'b0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      ntt_en_q  <= ntt_en_d;
      intt_en_q <= intt_en_d;
      beat_q    <= beat_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and abort flag; err_q is high only during the aborting CMPL.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign gnt          = gnt_q;
  assign core_ntt_en  = ntt_en_q;
  assign core_intt_en = intt_en_q;
  assign out_beat     = beat_q;

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// tb_ntt_job_arbiter
//   Self-checking bench for ntt_job_arbiter: a per-cycle vector table, a few
//   hand-written multi-cycle sequences, then randomized traffic. Every cycle is
//   also compared against a job-level reference model (active job record with
//   owner, mode and progress flags, plus the last-granted requester).
//   Define ARB_TIMEOUT_EN to also exercise the watchdog and err port.
module tb_ntt_job_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_mode;
  logic [1:0] req_ready;
  logic [1:0] gnt;
  logic       core_start;
  logic       core_ntt_en;
  logic       core_intt_en;
  logic       core_busy;
  logic       core_done_tick;
  logic       core_data_valid;
  logic [3:0] out_beat;
  logic [1:0] done;
`ifdef ARB_TIMEOUT_EN
  logic       err;
`endif

  ntt_job_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_mode        (req_mode),
    .req_ready       (req_ready),
    .gnt             (gnt),
    .core_start      (core_start),
    .core_ntt_en     (core_ntt_en),
    .core_intt_en    (core_intt_en),
    .core_busy       (core_busy),
    .core_done_tick  (core_done_tick),
    .core_data_valid (core_data_valid),
    .out_beat        (out_beat),
    .done            (done)
`ifdef ARB_TIMEOUT_EN
    ,
    .err             (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  // Job-level reference model.
  bit m_active;     // a job has been accepted and not yet completed
  bit m_started;    // core_start has been issued for the job
  bit m_finishing;  // the completion cycle is the current one
  bit m_timedout;   // completion was caused by the watchdog
  bit m_mode;       // latched transform type (1 = INTT)
  int m_owner;
  int m_last;       // requester granted most recently
  int m_beat;
  int m_run;        // RUN cycles without a done tick

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [1:0] rm;
    logic       busy;
    logic       dt;
    logic       dv;
    logic [1:0] ready;
    logic [1:0] gnt;
    logic       start;
    logic [1:0] en;
    logic [1:0] done;
    logic [3:0] beat;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] rv, input int last);
    if (rv == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
    return rv;
  endfunction

  task automatic model_reset();
    m_active    = 1'b0;
    m_started   = 1'b0;
    m_finishing = 1'b0;
    m_timedout  = 1'b0;
    m_mode      = 1'b0;
    m_owner     = 0;
    m_last      = 1;
    m_beat      = 0;
    m_run       = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cyc(input logic r, input logic [1:0] rv, input logic [1:0] rm,
                     input logic b, input logic t, input logic v);
    logic [1:0] e_ready, e_gnt, e_en, e_done;
    logic       e_start, e_err;
    logic [1:0] w;
    @(negedge clk);
    rst = r; req_valid = rv; req_mode = rm;
    core_busy = b; core_done_tick = t; core_data_valid = v;
    #1;
    cyc_n++;
    e_ready = (!m_active && !r) ? pick(rv, m_last) : 2'b00;
    e_gnt   = m_active ? 2'(1 << m_owner) : 2'b00;
    e_en    = m_active ? (m_mode ? 2'b01 : 2'b10) : 2'b00;
    e_start = m_active && !m_started && !b && !r;
    e_done  = (m_active && m_finishing && !m_timedout && !r) ? 2'(1 << m_owner) : 2'b00;
    e_err   = m_active && m_finishing && m_timedout;
    chk("m_ready", int'(req_ready), int'(e_ready));
    chk("m_gnt",   int'(gnt), int'(e_gnt));
    chk("m_start", int'(core_start), int'(e_start));
    chk("m_en",    int'({core_ntt_en, core_intt_en}), int'(e_en));
    chk("m_beat",  int'(out_beat), m_beat);
    chk("m_done",  int'(done), int'(e_done));
`ifdef ARB_TIMEOUT_EN
    chk("m_err",   int'(err), int'(e_err));
`else
    if (e_err) chk("m_err_unexpected", 1, 0);
`endif
    // Advance the model across the coming rising edge.
    if (r) begin
      model_reset();
    end else if (!m_active) begin
      if (rv != 2'b00) begin
        w           = pick(rv, m_last);
        m_owner     = w[1] ? 1 : 0;
        m_mode      = rm[m_owner];
        m_active    = 1'b1;
        m_started   = 1'b0;
        m_finishing = 1'b0;
        m_timedout  = 1'b0;
        m_beat      = 0;
      end
    end else if (!m_started) begin
      if (!b) begin
        m_started = 1'b1;
        m_run     = 0;
      end
    end else if (!m_finishing) begin
      if (v) m_beat = (m_beat + 1) % 16;
      if (t) begin
        m_finishing = 1'b1;
      end else begin
`ifdef ARB_TIMEOUT_EN
        m_run++;
        if (m_run == 60) begin
          m_finishing = 1'b1;
          m_timedout  = 1'b1;
        end
`endif
      end
    end else begin
      m_active = 1'b0;
      m_last   = m_owner;
    end
  endtask

  initial begin
    int pulses;
    logic r, b, t, v;
    logic [1:0] rv, rm;

    //         rst rv     rm     bsy  dt   dv   | ready  gnt    st   en     done   beat
    tbl[0]  = '{1, 2'b11, 2'b00, 0,   0,   0,     2'b00, 2'b00, 0,   2'b00, 2'b00, 4'd0};
    tbl[1]  = '{0, 2'b10, 2'b10, 0,   0,   0,     2'b10, 2'b00, 0,   2'b00, 2'b00, 4'd0};
    tbl[2]  = '{0, 2'b00, 2'b00, 1,   0,   0,     2'b00, 2'b10, 0,   2'b01, 2'b00, 4'd0};
    tbl[3]  = '{0, 2'b00, 2'b00, 0,   1,   0,     2'b00, 2'b10, 1,   2'b01, 2'b00, 4'd0};
    tbl[4]  = '{0, 2'b00, 2'b00, 0,   0,   1,     2'b00, 2'b10, 0,   2'b01, 2'b00, 4'd0};
    tbl[5]  = '{0, 2'b00, 2'b00, 0,   0,   1,     2'b00, 2'b10, 0,   2'b01, 2'b00, 4'd1};
    tbl[6]  = '{0, 2'b00, 2'b00, 0,   1,   0,     2'b00, 2'b10, 0,   2'b01, 2'b00, 4'd2};
    tbl[7]  = '{0, 2'b01, 2'b00, 0,   0,   0,     2'b00, 2'b10, 0,   2'b01, 2'b10, 4'd2};
    tbl[8]  = '{0, 2'b11, 2'b10, 0,   0,   0,     2'b01, 2'b00, 0,   2'b00, 2'b00, 4'd2};
    tbl[9]  = '{0, 2'b00, 2'b01, 0,   0,   0,     2'b00, 2'b01, 1,   2'b10, 2'b00, 4'd0};
    tbl[10] = '{1, 2'b00, 2'b00, 0,   0,   1,     2'b00, 2'b01, 0,   2'b10, 2'b00, 4'd0};
    tbl[11] = '{0, 2'b00, 2'b00, 0,   0,   0,     2'b00, 2'b00, 0,   2'b00, 2'b00, 4'd0};
    tbl[12] = '{0, 2'b11, 2'b00, 0,   0,   0,     2'b01, 2'b00, 0,   2'b00, 2'b00, 4'd0};
    tbl[13] = '{1, 2'b00, 2'b00, 0,   0,   0,     2'b00, 2'b01, 0,   2'b10, 2'b00, 4'd0};
    tbl[14] = '{0, 2'b00, 2'b00, 0,   0,   0,     2'b00, 2'b00, 0,   2'b00, 2'b00, 4'd0};

    rst = 1'b1; req_valid = '0; req_mode = '0;
    core_busy = 1'b0; core_done_tick = 1'b0; core_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rst, tbl[i].rv, tbl[i].rm, tbl[i].busy, tbl[i].dt, tbl[i].dv);
      chk("tbl_ready", int'(req_ready), int'(tbl[i].ready));
      chk("tbl_gnt",   int'(gnt), int'(tbl[i].gnt));
      chk("tbl_start", int'(core_start), int'(tbl[i].start));
      chk("tbl_en",    int'({core_ntt_en, core_intt_en}), int'(tbl[i].en));
      chk("tbl_done",  int'(done), int'(tbl[i].done));
      chk("tbl_beat",  int'(out_beat), int'(tbl[i].beat));
    end

    // Nominal job: accept at T, start at T+1, 16 beats, done at T+56.
    for (int i = 0; i <= 57; i++) begin
      cyc(1'b0, (i == 0) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      if (i >= 39 && i <= 54) begin end
      if (i == 0)  chk("nom_ready", int'(req_ready), 1);
      if (i == 1)  chk("nom_start", int'(core_start), 1);
      if (i >= 1 && i <= 56) chk("nom_en", int'({core_ntt_en, core_intt_en}), 2);
      if (i == 55) chk("nom_done_early", int'(done), 0);
      if (i == 56) chk("nom_done", int'(done), 1);
      if (i == 57) chk("nom_gnt_clr", int'(gnt), 0);
      // data_valid beats are driven on the following cycle slot below
      if (i == 38) break;
    end
    for (int i = 39; i <= 57; i++) begin
      cyc(1'b0, 2'b00, 2'b00, 1'b0, (i == 55), (i <= 54));
      if (i <= 54) chk("nom_beat", int'(out_beat), i - 39);
      if (i <= 56) chk("nom_en", int'({core_ntt_en, core_intt_en}), 2);
      if (i == 55) chk("nom_done_early", int'(done), 0);
      if (i == 56) chk("nom_done", int'(done), 1);
      if (i == 57) chk("nom_gnt_clr", int'(gnt), 0);
    end

    // Both requesting across two jobs: req0 first, req1 after an idle cycle.
    cyc(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 8; i++) begin
      cyc(1'b0, (i < 8) ? 2'b11 : 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      if (i == 0) chk("rr_first_ready", int'(req_ready), 1);
      if (i == 3) chk("rr_first_done", int'(done), 1);
      if (i == 3) chk("rr_no_ready_in_cmpl", int'(req_ready), 0);
      if (i == 4) chk("rr_second_ready", int'(req_ready), 2);
      if (i == 7) chk("rr_second_done", int'(done), 2);
    end

    // req1 INTT with req_mode toggling during the job.
    for (int i = 0; i <= 12; i++) begin
      cyc(1'b0, (i == 0) ? 2'b10 : 2'b00, (i == 0) ? 2'b10 : 2'((i % 2 == 1) ? 2'b00 : 2'b11),
          1'b0, (i == 10), 1'b0);
      if (i >= 1 && i <= 11) chk("intt_en", int'({core_ntt_en, core_intt_en}), 1);
      if (i == 11) chk("intt_done", int'(done), 2);
      if (i == 12) chk("intt_en_idle", int'({core_ntt_en, core_intt_en}), 0);
    end

    // core_busy high for 5 cycles after accept delays the single start pulse.
    pulses = 0;
    for (int i = 0; i <= 11; i++) begin
      cyc(1'b0, (i == 0) ? 2'b01 : 2'b00, 2'b00, (i >= 1 && i <= 5), (i == 9), 1'b0);
      pulses += int'(core_start);
      if (i >= 1 && i <= 8) chk("busy_start", int'(core_start), (i == 6) ? 1 : 0);
      if (i == 10) chk("busy_done", int'(done), 1);
    end
    chk("busy_pulses", pulses, 1);

    // Reset during RUN at out_beat 7 abandons the job without a done pulse.
    for (int i = 0; i <= 12; i++) begin
      cyc((i == 9), (i == 0) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0, (i >= 2));
      if (i == 9) chk("rst_beat7", int'(out_beat), 7);
      if (i == 10) begin
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_start", int'(core_start), 0);
        chk("rst_en", int'({core_ntt_en, core_intt_en}), 0);
        chk("rst_beat", int'(out_beat), 0);
      end
      if (i >= 9) chk("rst_no_done", int'(done), 0);
    end

`ifdef ARB_TIMEOUT_EN
    // Withheld done tick: err after 60 RUN cycles, no done, next job accepted.
    for (int i = 0; i <= 64; i++) begin
      cyc(1'b0, (i == 0 || i == 63) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      if (i == 61) chk("wd_err_early", int'(err), 0);
      if (i == 62) begin
        chk("wd_err", int'(err), 1);
        chk("wd_no_done", int'(done), 0);
      end
      if (i == 63) begin
        chk("wd_err_clr", int'(err), 0);
        chk("wd_gnt_clr", int'(gnt), 0);
        chk("wd_next_ready", int'(req_ready), 1);
      end
    end
    cyc(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized traffic checked against the model.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 249) == 0);
      rv = 2'($urandom_range(0, 3));
      rm = 2'($urandom_range(0, 3));
      b  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 7) == 0);
      v  = 1'($urandom_range(0, 1));
      cyc(r, rv, rm, b, t, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_job_arbiter.md
NTT_JOB_ARBITER -- requirements
Module: ntt_job_arbiter

Interface
- REQ-001: The block SHALL have one clock; reset is synchronous and active-high.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: req_valid  input  2  per-requester job request; bit i belongs to requester i.
- REQ-005: req_mode  input  2  per-requester transform type: 0 = NTT, 1 = INTT.
- REQ-006: req_ready  output  2  one-cycle accept pulse to the granted requester.
- REQ-007: gnt  output  2  one-hot owner of the core; all zero when no job is in progress.
- REQ-008: core_start  output  1  start strobe to the 16-point SDF NTT/INTT core.
- REQ-009: core_ntt_en, core_intt_en  output  1 each  transform-mode enables to the core.
- REQ-010: core_busy, core_done_tick, core_data_valid  input  1 each  status from the core.
- REQ-011: out_beat  output  4  index (0-15) of the current valid output beat.
- REQ-012: done  output  2  one-cycle job-complete pulse to the owning requester.
- REQ-013: err  output  1  one-cycle abort pulse; present only with ARB_TIMEOUT_EN.

Function
- REQ-014: The FSM SHALL have states IDLE, START, RUN and CMPL.
- REQ-015: IDLE, any req_valid high -> accept the winner, pulse req_ready[w], set gnt[w], latch req_mode[w], go to START.
- REQ-016: Arbitration SHALL be round-robin: the requester granted most recently has lower priority; after reset, requester 0 wins ties.
- REQ-017: START: core_start=1 only when core_busy=0; if core_busy=1, hold in START with core_start=0; go to RUN the cycle after core_start is asserted.
- REQ-018: core_start SHALL be high for exactly one cycle per job.
- REQ-019: Mode enables: latched NTT drives {core_ntt_en,core_intt_en}=10; latched INTT drives 01; in IDLE they drive 00.
- REQ-020: Mode enables SHALL be stable from START through CMPL; req_mode changes during a job are ignored.
- REQ-021: RUN: each cycle with core_data_valid=1 advances out_beat, which wraps 15 -> 0; out_beat SHALL be 0 at job accept.
- REQ-022: RUN, core_done_tick=1 -> CMPL.
- REQ-023: CMPL lasts one cycle: pulse done[w], clear gnt, update the round-robin pointer to w, return to IDLE.
- REQ-024: There SHALL be at least one IDLE cycle between consecutive jobs.
- REQ-025: Nominal latency SHALL be: accept at T, core_start at T+1, done pulse at T+56.
- REQ-026: req_valid outside IDLE SHALL be ignored; req_ready never pulses outside IDLE.
- REQ-027: core_done_tick seen outside RUN SHALL be ignored.

Reset
- REQ-028: While rst=1 at a clock edge: state=IDLE, round-robin pointer=1, and req_ready, gnt, core_start, both core enables, out_beat, done and err all 0.
- REQ-029: Reset mid-job SHALL abandon the job with no done pulse; the core is resynchronised through its own reset.

Configuration
- REQ-030: With ARB_TIMEOUT_EN defined, a 6-bit watchdog SHALL count RUN cycles; on reaching 60 without core_done_tick it pulses err, goes to CMPL without pulsing done, and otherwise behaves as REQ-023.
- REQ-031: Without ARB_TIMEOUT_EN, there SHALL be no err port and no watchdog, and RUN waits indefinitely.

Verification
- REQ-032: req_valid=01, mode=0 -> req_ready=01 at T; core_start at T+1; enables=10; 16 data_valid beats give out_beat 0..15; done=01 at T+56.
- REQ-033: req_valid=11 held across two jobs -> grant order 1st=req0, 2nd=req1; the 2nd req_ready comes at least 1 cycle after the 1st done.
- REQ-034: req1 in INTT mode; req_mode toggled during RUN -> enables stay 01 for the whole job.
- REQ-035: core_busy held high 5 cycles after accept -> core_start is delayed to the first cycle with core_busy=0, with exactly one pulse.
- REQ-036: rst asserted during RUN (out_beat=7) -> next cycle all outputs 0, state IDLE, no done pulse.
- REQ-037: With ARB_TIMEOUT_EN and core_done_tick withheld -> err pulses after 60 RUN cycles, done stays 0, gnt clears, the next request is accepted.
